remote_load_wb_buffer: RTL and testbench
========================================

REMOTE_LOAD_WB_BUFFER -- requirements
Module: remote_load_wb_buffer

Interface
REQ-001 SHALL have parameter els_p, default 2, FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have parameter data_width_p, default 32, load data width.
REQ-003 SHALL have parameter reg_addr_width_p, default 5, regfile address width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port resp_v_i  input  1  remote load response valid.
REQ-007 SHALL have port resp_ready_o  output  1  buffer can accept a response.
REQ-008 SHALL have port resp_float_wb_i  input  1  destination is FP regfile.
REQ-009 SHALL have port resp_reg_id_i  input  reg_addr_width_p  destination register.
REQ-010 SHALL have port resp_is_unsigned_i, resp_is_byte_i, resp_is_hex_i  input  1 each  load size/sign controls.
REQ-011 SHALL have port resp_part_sel_i  input  2  byte offset within word.
REQ-012 SHALL have port resp_data_i  input  data_width_p  raw word from network.
REQ-013 SHALL have port int_wb_v_o / int_wb_addr_o / int_wb_data_o  output  1 / reg_addr_width_p / data_width_p  integer writeback request.
REQ-014 SHALL have port int_wb_yumi_i  input  1  integer regfile port consumed the head entry.
REQ-015 SHALL have port float_wb_v_o / float_wb_addr_o / float_wb_data_o  output  1 / reg_addr_width_p / data_width_p  FP writeback request.
REQ-016 SHALL have port float_wb_yumi_i  input  1  FP regfile port consumed the head entry.

Function
REQ-017 SHALL enqueue on resp_v_i & resp_ready_o; resp_ready_o = not full, independent of same-cycle yumi.
REQ-018 SHALL present only the head entry: int_wb_v_o = nonempty & ~float_wb; float_wb_v_o = nonempty & float_wb; at most one asserted per cycle.
REQ-019 SHALL dequeue on int_wb_yumi_i | float_wb_yumi_i; yumi without matching valid is illegal (sim assertion).
REQ-020 SHALL store raw fields; alignment applied combinationally at head output.
REQ-021 SHALL, for byte ops, output data[8*part_sel +: 8], sign-extended from bit 7, zero-extended if is_unsigned.
REQ-022 SHALL, for hex ops, output data[16*part_sel[1] +: 16], sign/zero-extended likewise; part_sel[0] ignored.
REQ-023 SHALL otherwise output the full word unmodified; FP entries always pass raw word.
REQ-024 SHALL flag float_wb with byte or hex set as illegal (sim assertion); data passes raw.
REQ-025 SHALL use read/write pointers of log2(els_p) bits wrapping modulo els_p, plus a count of log2(els_p)+1 bits.
REQ-026 SHALL, on simultaneous enqueue and dequeue when nonempty and not full, keep count unchanged and advance both pointers.
REQ-027 SHALL deliver entries in arrival order; latency enqueue to wb valid is one cycle (no-bypass build).
REQ-028 SHALL hold head outputs stable while valid and not consumed.

Reset
REQ-029 SHALL, on reset_n_i low, asynchronously clear pointers and count; resp_ready_o=1, int_wb_v_o=0, float_wb_v_o=0 immediately.
REQ-030 SHALL discard all buffered entries on reset mid-operation; data/address outputs are don't-care while valid is low.
REQ-031 SHALL not enqueue in a cycle where reset_n_i is low, even if resp_v_i is high.

Configuration
REQ-032 SHALL, when macro REMOTE_LOAD_WB_BYPASS_EN is defined, present an arriving response on the wb outputs in the same cycle if the buffer is empty; if consumed that cycle it is not written.
REQ-033 SHALL, without REMOTE_LOAD_WB_BYPASS_EN, never drive wb valid combinationally from resp_v_i (registered one-cycle path only).

Verification
REQ-034 SHALL cover: signed byte, data=0x12_80_34_56, part_sel=2 -> int_wb_data_o=0xFFFFFF80 one cycle later.
REQ-035 SHALL cover: unsigned hex, data=0xBEEF_1234, part_sel=2 -> int_wb_data_o=0x0000BEEF.
REQ-036 SHALL cover: float_wb=1, reg_id=7, data=0x3F800000 -> float_wb_v_o=1, float_wb_addr_o=7, data 0x3F800000, int_wb_v_o=0.
REQ-037 SHALL cover: els_p=2, three back-to-back responses, yumi held low -> resp_ready_o=0 after two; third accepted after one yumi; order preserved.
REQ-038 SHALL cover: two entries buffered, reset_n_i pulsed low mid-cycle -> valids drop without clock edge, resp_ready_o=1.
REQ-039 SHALL cover: bypass build, empty buffer, resp plus same-cycle int_wb_yumi_i -> count stays 0, data seen same cycle.

Source files
------------

// File: rtl/remote_load_wb_buffer_if.sv
// remote_load_wb_buffer_if: response intake and integer/FP writeback signals of the
// remote load writeback buffer. The buffer sits on the slave modport; the network and
// regfile side sits on the master modport.
interface remote_load_wb_buffer_if #(
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned reg_addr_width_p = 5
);
    // Response from the network
    logic                        resp_v_i;
    logic                        resp_ready_o;
    logic                        resp_float_wb_i;
    logic [reg_addr_width_p-1:0] resp_reg_id_i;
    logic                        resp_is_unsigned_i;
    logic                        resp_is_byte_i;
    logic                        resp_is_hex_i;
    logic [1:0]                  resp_part_sel_i;
    logic [data_width_p-1:0]     resp_data_i;

    // Integer regfile writeback
    logic                        int_wb_v_o;
    logic [reg_addr_width_p-1:0] int_wb_addr_o;
    logic [data_width_p-1:0]     int_wb_data_o;
    logic                        int_wb_yumi_i;

    // FP regfile writeback
    logic                        float_wb_v_o;
    logic [reg_addr_width_p-1:0] float_wb_addr_o;
    logic [data_width_p-1:0]     float_wb_data_o;
    logic                        float_wb_yumi_i;

    modport slave (
        input  resp_v_i, resp_float_wb_i, resp_reg_id_i, resp_is_unsigned_i,
               resp_is_byte_i, resp_is_hex_i, resp_part_sel_i, resp_data_i,
               int_wb_yumi_i, float_wb_yumi_i,
        output resp_ready_o, int_wb_v_o, int_wb_addr_o, int_wb_data_o,
               float_wb_v_o, float_wb_addr_o, float_wb_data_o
    );

    modport master (
        output resp_v_i, resp_float_wb_i, resp_reg_id_i, resp_is_unsigned_i,
               resp_is_byte_i, resp_is_hex_i, resp_part_sel_i, resp_data_i,
               int_wb_yumi_i, float_wb_yumi_i,
        input  resp_ready_o, int_wb_v_o, int_wb_addr_o, int_wb_data_o,
               float_wb_v_o, float_wb_addr_o, float_wb_data_o
    );
endinterface

// File: rtl/remote_load_wb_buffer.sv
// remote_load_wb_buffer: in-order FIFO of remote load responses feeding the integer and
// FP regfile writeback ports. Raw response fields are stored; byte/halfword alignment and
// sign/zero extension are applied combinationally on the head entry.
// Build macro REMOTE_LOAD_WB_BYPASS_EN: an arriving response is presented on the
// writeback outputs in the same cycle when the buffer is empty (default: registered only).
module remote_load_wb_buffer #(
    parameter int unsigned els_p            = 2,
    parameter int unsigned data_width_p     = 32,
    parameter int unsigned reg_addr_width_p = 5
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    remote_load_wb_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(els_p);
    localparam int unsigned CntW = PtrW + 1;

    // Entry storage (no reset: contents are only meaningful below r_count)
    logic [data_width_p-1:0]     r_data     [els_p];
    logic [reg_addr_width_p-1:0] r_reg_id   [els_p];
    logic                        r_float    [els_p];
    logic                        r_unsigned [els_p];
    logic                        r_byte     [els_p];
    logic                        r_hex      [els_p];
    logic [1:0]                  r_part_sel [els_p];

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_enq;
    logic w_yumi;
    logic w_wr;
    logic w_rd;

    logic                        w_head_v;
    logic                        w_head_float;
    logic                        w_head_unsigned;
    logic                        w_head_byte;
    logic                        w_head_hex;
    logic [1:0]                  w_head_part;
    logic [reg_addr_width_p-1:0] w_head_reg_id;
    logic [data_width_p-1:0]     w_head_data;
    logic [data_width_p-1:0]     w_int_data;
    logic [7:0]                  w_byte;
    logic [15:0]                 w_hex;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CntW'(els_p));
    assign w_enq   = bus.resp_v_i & ~w_full;
    assign w_yumi  = bus.int_wb_yumi_i | bus.float_wb_yumi_i;
    assign w_rd    = w_yumi & ~w_empty;

`ifdef REMOTE_LOAD_WB_BYPASS_EN
    // A response consumed while bypassing an empty buffer never occupies a slot.
    assign w_wr = w_enq & ~(w_empty & w_yumi);
`else
    assign w_wr = w_enq;
`endif

    assign bus.resp_ready_o = ~w_full;

    // Select the head entry: stored slot, or the arriving response when bypassing.
    always_comb begin
        w_head_v        = ~w_empty;
        w_head_float    = r_float[r_rd_ptr];
        w_head_unsigned = r_unsigned[r_rd_ptr];
        w_head_byte     = r_byte[r_rd_ptr];
        w_head_hex      = r_hex[r_rd_ptr];
        w_head_part     = r_part_sel[r_rd_ptr];
        w_head_reg_id   = r_reg_id[r_rd_ptr];
        w_head_data     = r_data[r_rd_ptr];
`ifdef REMOTE_LOAD_WB_BYPASS_EN
        if (w_empty) begin
            w_head_v        = bus.resp_v_i & reset_n_i;
            w_head_float    = bus.resp_float_wb_i;
            w_head_unsigned = bus.resp_is_unsigned_i;
            w_head_byte     = bus.resp_is_byte_i;
            w_head_hex      = bus.resp_is_hex_i;
            w_head_part     = bus.resp_part_sel_i;
            w_head_reg_id   = bus.resp_reg_id_i;
            w_head_data     = bus.resp_data_i;
        end
`endif
    end

    // Pointer and occupancy tracking; reset discards every buffered entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture raw response fields into the tail slot.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_data[r_wr_ptr]     <= bus.resp_data_i;
            r_reg_id[r_wr_ptr]   <= bus.resp_reg_id_i;
            r_float[r_wr_ptr]    <= bus.resp_float_wb_i;
            r_unsigned[r_wr_ptr] <= bus.resp_is_unsigned_i;
            r_byte[r_wr_ptr]     <= bus.resp_is_byte_i;
            r_hex[r_wr_ptr]      <= bus.resp_is_hex_i;
            r_part_sel[r_wr_ptr] <= bus.resp_part_sel_i;
        end
    end

    // Align and extend sub-word integer loads; byte takes priority over halfword.
    always_comb begin
        w_byte     = w_head_data[{w_head_part, 3'b000} +: 8];
        w_hex      = w_head_data[{w_head_part[1], 4'b0000} +: 16];
        w_int_data = w_head_data;
        if (w_head_byte) begin
            w_int_data = {{(data_width_p-8){~w_head_unsigned & w_byte[7]}}, w_byte};
        end else if (w_head_hex) begin
            w_int_data = {{(data_width_p-16){~w_head_unsigned & w_hex[15]}}, w_hex};
        end
    end

    assign bus.int_wb_v_o      = w_head_v & ~w_head_float;
    assign bus.int_wb_addr_o   = w_head_reg_id;
    assign bus.int_wb_data_o   = w_int_data;
    assign bus.float_wb_v_o    = w_head_v & w_head_float;
    assign bus.float_wb_addr_o = w_head_reg_id;
    assign bus.float_wb_data_o = w_head_data;

    // Consuming a port requires that port's valid in the same cycle.
    a_int_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.int_wb_yumi_i |-> bus.int_wb_v_o);
    a_float_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.float_wb_yumi_i |-> bus.float_wb_v_o);
    // FP loads are whole-word only.
    a_float_no_subword: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (bus.resp_v_i & bus.resp_float_wb_i) |-> ~(bus.resp_is_byte_i | bus.resp_is_hex_i));
endmodule

// File: tb/tb_remote_load_wb_buffer.sv
// tb_remote_load_wb_buffer: scoreboard bench for remote_load_wb_buffer (els_p = 2).
// Expected writebacks are pushed when a response is accepted and compared at the head.
module tb_remote_load_wb_buffer;
    localparam int Els = 2;

    typedef struct packed {
        logic        fl;
        logic [4:0]  rid;
        logic        uns;
        logic        byt;
        logic        hx;
        logic [1:0]  ps;
        logic [31:0] d;
    } resp_t;

    typedef struct packed {
        logic        fl;
        logic [4:0]  rid;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    remote_load_wb_buffer_if #(.data_width_p(32), .reg_addr_width_p(5)) bus ();

    remote_load_wb_buffer #(
        .els_p           (Els),
        .data_width_p    (32),
        .reg_addr_width_p(5)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference load formatting, written out per byte lane.
    function automatic logic [31:0] ref_data(input resp_t r);
        logic [7:0]  b;
        logic [15:0] h;
        if (r.fl) return r.d;
        if (r.byt) begin
            case (r.ps)
                2'd0:    b = r.d[7:0];
                2'd1:    b = r.d[15:8];
                2'd2:    b = r.d[23:16];
                default: b = r.d[31:24];
            endcase
            return r.uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (r.hx) begin
            h = r.ps[1] ? r.d[31:16] : r.d[15:0];
            return r.uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return r.d;
    endfunction

    function automatic exp_t to_exp(input resp_t r);
        exp_t e;
        e.fl  = r.fl;
        e.rid = r.rid;
        e.d   = ref_data(r);
        return e;
    endfunction

    function automatic resp_t mk(input logic fl, input logic [4:0] rid, input logic uns,
                                 input logic byt, input logic hx, input logic [1:0] ps,
                                 input logic [31:0] d);
        resp_t r;
        r.fl = fl; r.rid = rid; r.uns = uns; r.byt = byt; r.hx = hx; r.ps = ps; r.d = d;
        return r;
    endfunction

    function automatic resp_t rand_resp();
        resp_t r;
        int unsigned m;
        m     = $urandom_range(0, 3);
        r.d   = $urandom();
        r.rid = 5'($urandom_range(0, 31));
        r.ps  = 2'($urandom_range(0, 3));
        r.uns = 1'($urandom_range(0, 1));
        r.fl  = (m == 3);
        r.byt = (m == 1);
        r.hx  = (m == 2);
        return r;
    endfunction

    task automatic drive_resp(input logic rv, input resp_t r);
        bus.resp_v_i           = rv;
        bus.resp_float_wb_i    = r.fl;
        bus.resp_reg_id_i      = r.rid;
        bus.resp_is_unsigned_i = r.uns;
        bus.resp_is_byte_i     = r.byt;
        bus.resp_is_hex_i      = r.hx;
        bus.resp_part_sel_i    = r.ps;
        bus.resp_data_i        = r.d;
    endtask

    task automatic idle_inputs();
        bus.resp_v_i        = 1'b0;
        bus.int_wb_yumi_i   = 1'b0;
        bus.float_wb_yumi_i = 1'b0;
    endtask

    // Compare DUT outputs with the scoreboard head.
    task automatic check_outputs(input string tag);
        logic hv;
        exp_t h;
        hv = (sb.size() != 0);
        h  = '0;
        if (hv) h = sb[0];
        check_eq({tag, ".ready"}, 32'(bus.resp_ready_o), 32'(sb.size() < Els));
        check_eq({tag, ".int_v"}, 32'(bus.int_wb_v_o), 32'(hv & ~h.fl));
        check_eq({tag, ".flt_v"}, 32'(bus.float_wb_v_o), 32'(hv & h.fl));
        if (hv && !h.fl) begin
            check_eq({tag, ".int_addr"}, 32'(bus.int_wb_addr_o), 32'(h.rid));
            check_eq({tag, ".int_data"}, bus.int_wb_data_o, h.d);
        end
        if (hv && h.fl) begin
            check_eq({tag, ".flt_addr"}, 32'(bus.float_wb_addr_o), 32'(h.rid));
            check_eq({tag, ".flt_data"}, bus.float_wb_data_o, h.d);
        end
    endtask

    // One clock cycle starting at a negedge: check, drive, advance, update model.
    task automatic cycle(input string tag, input logic rv, input resp_t r, input logic yumi);
        logic acc;
        logic pop;
        check_outputs(tag);
        drive_resp(rv, r);
        bus.int_wb_yumi_i   = 1'b0;
        bus.float_wb_yumi_i = 1'b0;
        pop = yumi && (sb.size() != 0);
        if (pop) begin
            if (sb[0].fl) bus.float_wb_yumi_i = 1'b1;
            else          bus.int_wb_yumi_i   = 1'b1;
        end
        acc = rv && (sb.size() < Els);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, ".no_comb_v"}, 32'(bus.int_wb_v_o | bus.float_wb_v_o), 32'd0);
        end
        @(negedge clk);
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back(to_exp(r));
    endtask

    initial begin
        resp_t nil;
        resp_t r;
        n_checks = 0;
        n_pass   = 0;
        nil      = '0;
        rst_n    = 1'b0;
        idle_inputs();
        drive_resp(1'b1, mk(1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF));
        #1;
        check_eq("rst.ready", 32'(bus.resp_ready_o), 32'd1);
        check_eq("rst.int_v", 32'(bus.int_wb_v_o), 32'd0);
        check_eq("rst.flt_v", 32'(bus.float_wb_v_o), 32'd0);
        // resp_v_i high across an edge while in reset must not enqueue
        @(posedge clk);
        #1;
        check_eq("rst_edge.int_v", 32'(bus.int_wb_v_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);

`ifndef REMOTE_LOAD_WB_BYPASS_EN
        check_outputs("post_rst");

        // Signed byte, lane 2
        cycle("b_s.send", 1'b1, mk(1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1280_3456), 1'b0);
        check_eq("b_s.lit", bus.int_wb_data_o, 32'hFFFF_FF80);
        cycle("b_s.take", 1'b0, nil, 1'b1);

        // Unsigned halfword, upper half
        cycle("h_u.send", 1'b1, mk(1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 2'd2, 32'hBEEF_1234), 1'b0);
        check_eq("h_u.lit", bus.int_wb_data_o, 32'h0000_BEEF);
        cycle("h_u.take", 1'b0, nil, 1'b1);

        // FP word writeback
        cycle("fp.send", 1'b1, mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3F80_0000), 1'b0);
        check_eq("fp.lit_v", 32'(bus.float_wb_v_o), 32'd1);
        check_eq("fp.lit_addr", 32'(bus.float_wb_addr_o), 32'd7);
        check_eq("fp.lit_data", bus.float_wb_data_o, 32'h3F80_0000);
        check_eq("fp.lit_int_v", 32'(bus.int_wb_v_o), 32'd0);
        cycle("fp.take", 1'b0, nil, 1'b1);

        // Fill to full, back-pressure the third, accept it after one yumi
        cycle("full.a", 1'b1, mk(1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 2'd0, 32'hAAAA_0001), 1'b0);
        cycle("full.b", 1'b1, mk(1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 2'd3, 32'h9BCD_0002), 1'b0);
        check_eq("full.lit_ready", 32'(bus.resp_ready_o), 32'd0);
        r = mk(1'b0, 5'd12, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_8003);
        cycle("full.c_blk", 1'b1, r, 1'b1);
        cycle("full.c_acc", 1'b1, r, 1'b0);
        cycle("full.drain0", 1'b0, nil, 1'b1);
        cycle("full.drain1", 1'b0, nil, 1'b1);
        check_outputs("full.empty");

        // Reset with two entries buffered
        cycle("mid.d", 1'b1, mk(1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1111_2222), 1'b0);
        cycle("mid.e", 1'b1, mk(1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3333_4444), 1'b0);
        idle_inputs();
        check_eq("mid.pre_v", 32'(bus.int_wb_v_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid.rst_int_v", 32'(bus.int_wb_v_o), 32'd0);
        check_eq("mid.rst_flt_v", 32'(bus.float_wb_v_o), 32'd0);
        check_eq("mid.rst_ready", 32'(bus.resp_ready_o), 32'd1);
        sb.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("mid.after");

        // Randomised traffic
        for (int i = 0; i < 120; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), rand_resp(), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            if (sb.size() != 0) cycle("drain", 1'b0, nil, 1'b1);
        end
        idle_inputs();
        check_outputs("final");
`else
        // Bypass: empty buffer, response consumed in the same cycle
        drive_resp(1'b1, mk(1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1280_3456));
        bus.int_wb_yumi_i = 1'b1;
        #1;
        check_eq("byp.int_v", 32'(bus.int_wb_v_o), 32'd1);
        check_eq("byp.addr", 32'(bus.int_wb_addr_o), 32'd4);
        check_eq("byp.data", bus.int_wb_data_o, 32'hFFFF_FF80);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("byp.after_v", 32'(bus.int_wb_v_o), 32'd0);
        check_eq("byp.after_ready", 32'(bus.resp_ready_o), 32'd1);
        // Bypass not consumed: the entry is stored and stays at the head
        @(negedge clk);
        drive_resp(1'b1, mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3F80_0000));
        #1;
        check_eq("byp2.flt_v", 32'(bus.float_wb_v_o), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("byp2.held_v", 32'(bus.float_wb_v_o), 32'd1);
        check_eq("byp2.held_data", bus.float_wb_data_o, 32'h3F80_0000);
        bus.float_wb_yumi_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("byp2.gone_v", 32'(bus.float_wb_v_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
